gpio_serial_loader: RTL and testbench

Sequencer that shifts per-pad configuration words into the two user-project GPIO control-block chains. It generates the serial clock, data and load strobes that drive the management GPIO configuration path. It sits in housekeeping, next to the management GPIO buffering, and is triggered by a software "apply configuration" write. Both chains, the low pads and the high pads, are loaded in parallel from a registered configuration store that this block addresses.

---
 rtl/gpio_serial_loader_pkg.sv | 27 ++
 rtl/gpio_serial_loader_if.sv | 51 +++++
 rtl/gpio_serial_loader_clkgen.sv | 33 +++
 rtl/gpio_serial_loader.sv | 124 ++++++++++++
 tb/tb_gpio_serial_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_serial_loader_pkg.sv
// rtl/gpio_serial_loader_pkg.sv - shared state encoding, defaults and load-length helper (optional feature: GPIO_SERIAL_BITBANG_EN)
package gpio_serial_loader_pkg;

  localparam int DEF_CFG_WIDTH = 13;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    LATCH = ST_LATCH,
    SHIFT = ST_SHIFT,
    LOAD  = ST_LOAD,
    DONE  = ST_DONE
  } state_t;

  // Cycles from the edge that samples start to the edge after which done is high.
  function automatic int total_load_cycles(input int num_pads, input int cfg_width, input int clk_div);
    return 1 + num_pads * (2 + 2 * clk_div * cfg_width) + clk_div;
  endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// rtl/gpio_serial_loader_if.sv - loader request, config store and serial chain bundle (optional feature: GPIO_SERIAL_BITBANG_EN)
interface gpio_serial_loader_if
  import gpio_serial_loader_pkg::*;
#(
  parameter int NUM_PADS  = 19,
  parameter int CFG_WIDTH = DEF_CFG_WIDTH
);
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  logic                 start;
  logic [AW-1:0]        cfg_addr;
  logic [CFG_WIDTH-1:0] cfg_data_1;
  logic [CFG_WIDTH-1:0] cfg_data_2;
  logic                 serial_clock;
  logic                 serial_load;
  logic                 serial_data_1;
  logic                 serial_data_2;
  logic                 busy;
  logic                 done;

`ifdef GPIO_SERIAL_BITBANG_EN
  logic bb_enable;
  logic bb_clock;
  logic bb_load;
  logic bb_data_1;
  logic bb_data_2;

  modport master (
    input  start, cfg_data_1, cfg_data_2,
    input  bb_enable, bb_clock, bb_load, bb_data_1, bb_data_2,
    output cfg_addr, serial_clock, serial_load, serial_data_1, serial_data_2, busy, done
  );

  modport slave (
    output start, cfg_data_1, cfg_data_2,
    output bb_enable, bb_clock, bb_load, bb_data_1, bb_data_2,
    input  cfg_addr, serial_clock, serial_load, serial_data_1, serial_data_2, busy, done
  );
`else
  modport master (
    input  start, cfg_data_1, cfg_data_2,
    output cfg_addr, serial_clock, serial_load, serial_data_1, serial_data_2, busy, done
  );

  modport slave (
    output start, cfg_data_1, cfg_data_2,
    input  cfg_addr, serial_clock, serial_load, serial_data_1, serial_data_2, busy, done
  );
`endif

endinterface

// File: rtl/gpio_serial_loader_clkgen.sv
// rtl/gpio_serial_loader_clkgen.sv - serial clock phase counter, half-period tick and bit-end flags
module gpio_serial_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic phase,
  output logic bit_end
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick    = run && (cnt == LAST);
  assign bit_end = tick && phase;

  // Dropping run restarts the next bit or strobe on a fresh low half.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// rtl/gpio_serial_loader.sv - shifts per-pad config words into both GPIO chains (optional feature: GPIO_SERIAL_BITBANG_EN)
module gpio_serial_loader
  import gpio_serial_loader_pkg::*;
#(
  parameter int NUM_PADS  = 19,
  parameter int CFG_WIDTH = DEF_CFG_WIDTH,
  parameter int CLK_DIV   = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  gpio_serial_loader_if.master bus
);
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
  localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_WIDTH - 1);

  state_t               state;
  state_t               state_next;
  logic [AW-1:0]        pad_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [CFG_WIDTH-1:0] sr_1;
  logic [CFG_WIDTH-1:0] sr_2;
  logic                 run;
  logic                 tick;
  logic                 phase;
  logic                 bit_end;
  logic                 bb_mode;
  logic                 accept;

`ifdef GPIO_SERIAL_BITBANG_EN
  assign bb_mode = bus.bb_enable;
`else
  assign bb_mode = 1'b0;
`endif

  // The done flop is still high in the first IDLE cycle, which blocks an immediate restart.
  assign accept = bus.start && !bb_mode && !bus.done;
  assign run    = (state == SHIFT) || (state == LOAD);

  gpio_serial_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .run     (run),
    .tick    (tick),
    .phase   (phase),
    .bit_end (bit_end)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = FETCH;
      FETCH:   state_next = LATCH;
      LATCH:   state_next = SHIFT;
      SHIFT:   if (bit_end && (bit_cnt == LAST_BIT)) state_next = (pad_cnt == '0) ? LOAD : FETCH;
      LOAD:    if (tick) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pad_cnt <= '0;
      bit_cnt <= '0;
      sr_1    <= '0;
      sr_2    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) pad_cnt <= LAST_PAD;
        LATCH: begin
          sr_1    <= bus.cfg_data_1;
          sr_2    <= bus.cfg_data_2;
          bit_cnt <= '0;
        end
        SHIFT: if (bit_end) begin
          sr_1    <= sr_1 << 1;
          sr_2    <= sr_2 << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if ((bit_cnt == LAST_BIT) && (pad_cnt != '0)) pad_cnt <= pad_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_addr = pad_cnt;

  // Outputs trail the state by one cycle, so data and clock fall change on the same edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.serial_clock  <= 1'b0;
      bus.serial_load   <= 1'b0;
      bus.serial_data_1 <= 1'b0;
      bus.serial_data_2 <= 1'b0;
    end else begin
      bus.busy          <= (state == FETCH) || (state == LATCH) || (state == SHIFT) || (state == LOAD);
      bus.done          <= (state == DONE);
      bus.serial_load   <= (state == LOAD);
      bus.serial_clock  <= (state == SHIFT) && phase;
      bus.serial_data_1 <= (state == SHIFT) && sr_1[CFG_WIDTH-1];
      bus.serial_data_2 <= (state == SHIFT) && sr_2[CFG_WIDTH-1];
`ifdef GPIO_SERIAL_BITBANG_EN
      if ((state == IDLE) && bus.bb_enable) begin
        bus.serial_clock  <= bus.bb_clock;
        bus.serial_load   <= bus.bb_load;
        bus.serial_data_1 <= bus.bb_data_1;
        bus.serial_data_2 <= bus.bb_data_2;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb/tb_gpio_serial_loader.sv - randomized self-checking bench for gpio_serial_loader (bitbang checks with GPIO_SERIAL_BITBANG_EN)
module tb_gpio_serial_loader;
  import gpio_serial_loader_pkg::*;

  localparam int NP = 2;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_serial_loader_if #(.NUM_PADS(NP), .CFG_WIDTH(CW)) if_a ();
  gpio_serial_loader_if #(.NUM_PADS(NP), .CFG_WIDTH(CW)) if_b ();

  gpio_serial_loader #(.NUM_PADS(NP), .CFG_WIDTH(CW), .CLK_DIV(1)) dut_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (if_a.master)
  );

  gpio_serial_loader #(.NUM_PADS(NP), .CFG_WIDTH(CW), .CLK_DIV(4)) dut_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (if_b.master)
  );

  logic sel = 1'b0;
  logic start_r = 1'b0;
  assign if_a.start = start_r && !sel;
  assign if_b.start = start_r && sel;

`ifdef GPIO_SERIAL_BITBANG_EN
  logic bb_en = 1'b0;
  logic bb_clk = 1'b0;
  logic bb_ld = 1'b0;
  logic bb_d1 = 1'b0;
  logic bb_d2 = 1'b0;
  assign if_a.bb_enable = bb_en;
  assign if_a.bb_clock  = bb_clk;
  assign if_a.bb_load   = bb_ld;
  assign if_a.bb_data_1 = bb_d1;
  assign if_a.bb_data_2 = bb_d2;
  assign if_b.bb_enable = bb_en;
  assign if_b.bb_clock  = bb_clk;
  assign if_b.bb_load   = bb_ld;
  assign if_b.bb_data_1 = bb_d1;
  assign if_b.bb_data_2 = bb_d2;
`endif

  // Configuration store with one cycle of read latency.
  logic [CW-1:0] mem_1 [NP];
  logic [CW-1:0] mem_2 [NP];
  always_ff @(posedge clk) begin
    if_a.cfg_data_1 <= mem_1[if_a.cfg_addr];
    if_a.cfg_data_2 <= mem_2[if_a.cfg_addr];
    if_b.cfg_data_1 <= mem_1[if_b.cfg_addr];
    if_b.cfg_data_2 <= mem_2[if_b.cfg_addr];
  end

  logic sc, sl, sd1, sd2, bsy, dn;
  logic [0:0] addr;
  assign sc   = sel ? if_b.serial_clock  : if_a.serial_clock;
  assign sl   = sel ? if_b.serial_load   : if_a.serial_load;
  assign sd1  = sel ? if_b.serial_data_1 : if_a.serial_data_1;
  assign sd2  = sel ? if_b.serial_data_2 : if_a.serial_data_2;
  assign bsy  = sel ? if_b.busy          : if_a.busy;
  assign dn   = sel ? if_b.done          : if_a.done;
  assign addr = sel ? if_b.cfg_addr      : if_a.cfg_addr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sc"},   sc,   0);
    check({tag, "_sl"},   sl,   0);
    check({tag, "_sd"},   {sd1, sd2}, 0);
    check({tag, "_busy"}, bsy,  0);
    check({tag, "_done"}, dn,   0);
    check({tag, "_addr"}, addr, 0);
  endtask

  task automatic run_load(input string tag, input int cd, input bit poke_start, input bit poke_bb);
    logic h_sc  [1024];
    logic h_sd1 [1024];
    logic h_sd2 [1024];
    int e, per, n_load, first_load, n_done, done_at, busy_err, clash;
    int rises, last_rise, bad_bits, bad_hi, bad_per, bad_stab, pad, bt;
    sel = (cd == 4);
    e = 1 + NP * (2 + 2 * cd * CW) + cd;
    per = 2 + 2 * cd * CW;
    n_load = 0; first_load = -1; n_done = 0; done_at = -1; busy_err = 0; clash = 0;
    @(negedge clk);
    start_r = 1'b1;
    for (int m = 0; m < e + 4; m++) begin
      @(negedge clk);
      h_sc[m] = sc; h_sd1[m] = sd1; h_sd2[m] = sd2;
      if (m < e + 1 && bsy !== ((m >= 1) && (m < e))) busy_err++;
      if (m == 0)       check({tag, "_addr_first"}, addr, 1);
      if (m == per - 1) check({tag, "_addr_hold"},  addr, 1);
      if (m == per)     check({tag, "_addr_next"},  addr, 0);
      if (dn) begin n_done++; done_at = m; end
      if (m < e && sl) begin
        n_load++;
        if (first_load < 0) first_load = m;
        if (sc) clash++;
      end
      start_r = poke_start && (m == 10);
      if (poke_bb && m >= 20 && m < e) begin
`ifdef GPIO_SERIAL_BITBANG_EN
        bb_en = 1'b1;
        {bb_clk, bb_ld, bb_d1, bb_d2} = 4'($urandom);
`endif
      end
    end
    start_r = 1'b0;
`ifdef GPIO_SERIAL_BITBANG_EN
    bb_en = 1'b0;
    {bb_clk, bb_ld, bb_d1, bb_d2} = 4'b0;
`endif
    rises = 0; last_rise = -1; bad_bits = 0; bad_hi = 0; bad_per = 0; bad_stab = 0;
    for (int m = cd + 1; m < e; m++) begin
      if (h_sc[m] && !h_sc[m-1]) begin
        if (rises < NP * CW) begin
          pad = NP - 1 - rises / CW;
          bt  = CW - 1 - rises % CW;
          if (h_sd1[m] !== mem_1[pad][bt] || h_sd2[m] !== mem_2[pad][bt]) bad_bits++;
        end
        for (int k = 0; k < cd; k++) if (!h_sc[m+k]) bad_hi++;
        if (h_sc[m+cd]) bad_hi++;
        if ((rises % CW) != 0 && (m - last_rise) != 2 * cd) bad_per++;
        for (int k = m - cd; k < m + cd; k++)
          if (h_sd1[k] !== h_sd1[m] || h_sd2[k] !== h_sd2[m]) bad_stab++;
        last_rise = m;
        rises++;
      end
    end
    check({tag, "_rises"},      rises, NP * CW);
    check({tag, "_bits"},       bad_bits, 0);
    check({tag, "_high_len"},   bad_hi, 0);
    check({tag, "_bit_period"}, bad_per, 0);
    check({tag, "_data_stable"}, bad_stab, 0);
    check({tag, "_load_len"},   n_load, cd);
    check({tag, "_load_start"}, first_load, e - cd);
    check({tag, "_load_clk"},   clash, 0);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_done_time"},  done_at, e);
    check({tag, "_busy"},       busy_err, 0);
  endtask

  task automatic reset_mid(input int cd);
    int rises, bad;
    logic prev;
    sel = (cd == 4);
    rises = 0; prev = 1'b0; bad = 0;
    @(negedge clk);
    start_r = 1'b1;
    for (int m = 0; m < 3000 && rises < 5; m++) begin
      @(negedge clk);
      start_r = 1'b0;
      if (sc && !prev) rises++;
      prev = sc;
    end
    check("rst_reach_bit5", rises, 5);
    repeat (cd + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    for (int m = 0; m < 300; m++) begin
      @(negedge clk);
      if (sl || dn || bsy) bad++;
    end
    check("rst_no_strobe", bad, 0);
  endtask

`ifdef GPIO_SERIAL_BITBANG_EN
  task automatic bitbang_idle();
    logic [3:0] drv;
    int err, busy_seen;
    sel = 1'b0; err = 0; busy_seen = 0;
    @(negedge clk);
    bb_en = 1'b1;
    drv = 4'($urandom);
    {bb_clk, bb_ld, bb_d1, bb_d2} = drv;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if ({sc, sl, sd1, sd2} !== drv) err++;
      if (bsy) busy_seen++;
      start_r = (i == 5);
      drv = 4'($urandom);
      drv[3] = ~bb_clk;
      {bb_clk, bb_ld, bb_d1, bb_d2} = drv;
    end
    check("bb_follow", err, 0);
    check("bb_start_ignored", busy_seen, 0);
    start_r = 1'b0;
    bb_en = 1'b0;
    {bb_clk, bb_ld, bb_d1, bb_d2} = 4'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    mem_1[0] = '0; mem_1[1] = '0; mem_2[0] = '0; mem_2[1] = '0;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_idle_outputs("reset_a");
    sel = 1'b1;
    check_idle_outputs("reset_b");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_quiet_sc", sc, 0);

    mem_1[1] = 13'h1ABC; mem_2[1] = 13'h0001;
    mem_1[0] = 13'h0155; mem_2[0] = 13'h1FFF;
    run_load("basic", 1, 1'b0, 1'b0);
    run_load("div4", 4, 1'b0, 1'b0);
    run_load("restart", 4, 1'b1, 1'b0);
    run_load("restart1", 1, 1'b1, 1'b0);

    reset_mid(4);
    run_load("after_rst", 4, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < NP; p++) begin
        mem_1[p] = CW'($urandom);
        mem_2[p] = CW'($urandom);
      end
      run_load("rand", (i % 2 == 1) ? 4 : 1, (i == 2), 1'b0);
    end

`ifdef GPIO_SERIAL_BITBANG_EN
    bitbang_idle();
    run_load("bb_busy", 4, 1'b0, 1'b1);
    run_load("bb_busy1", 1, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
